// File: rtl/logic_proc_ctrl.sv
// Sequencer and serial datapath for the bit-serial logic processor.
// Drives load/shift strobes of an external register pair and feeds back f(A_out,B_out).
module logic_proc_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Execute,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic [2:0] F,
  input  logic [1:0] R,
  input  logic       A_out,
  input  logic       B_out,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       Shift_En,
  output logic       A_In,
  output logic       B_In,
  output logic       Busy,
  output logic       Done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_f, w_f_nxt;
  logic [1:0]       r_r, w_r_nxt;
  logic             w_fn;

  function automatic logic fn_eval(input logic [2:0] sel, input logic a, input logic b);
    logic y;
    case (sel[1:0])
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = 1'b1;
    endcase
    // Upper select bit inverts the base function (so 111 is constant 0).
    return sel[2] ? ~y : y;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f     <= 3'b000;
      r_r     <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_f     <= w_f_nxt;
      r_r     <= w_r_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_f_nxt     = r_f;
    w_r_nxt     = r_r;
    Ld_A        = 1'b0;
    Ld_B        = 1'b0;
    Shift_En    = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Execute) begin
          w_f_nxt     = F;
          w_r_nxt     = R;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          // Loads are masked while reset is held even though the state already reads IDLE.
          Ld_A = LoadA & Reset;
          Ld_B = LoadB & Reset;
        end
      end
      S_SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        Done = 1'b1;
        if (!Execute) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_fn = fn_eval(r_f, A_out, B_out);

  always_comb begin
    A_In = A_out;
    B_In = B_out;
    case (r_r)
      2'b01: B_In = w_fn;
      2'b10: A_In = w_fn;
      2'b11: begin
        A_In = B_out;
        B_In = A_out;
      end
      default: begin
        A_In = A_out;
        B_In = B_out;
      end
    endcase
  end

endmodule

// File: tb/tb_logic_proc_ctrl.sv
// Bench for logic_proc_ctrl: attaches a behavioural 8-bit register pair and
// compares whole-operation results with a bitwise reference of each function.
module tb_logic_proc_ctrl;

  localparam int WIDTH = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Execute = 1'b0;
  logic       LoadA = 1'b0;
  logic       LoadB = 1'b0;
  logic [2:0] F = 3'b000;
  logic [1:0] R = 2'b00;
  logic       A_out, B_out;
  logic       Ld_A, Ld_B, Shift_En, A_In, B_In, Busy, Done;

  logic [7:0] sw = 8'h00;
  logic [7:0] regA = 8'h00;
  logic [7:0] regB = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  logic_proc_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Execute(Execute), .LoadA(LoadA), .LoadB(LoadB),
    .F(F), .R(R), .A_out(A_out), .B_out(B_out),
    .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En), .A_In(A_In), .B_In(B_In),
    .Busy(Busy), .Done(Done)
  );

  // Register pair the controller drives: load from switches, or shift right with MSB input.
  assign A_out = regA[0];
  assign B_out = regB[0];
  always_ff @(posedge Clk) begin
    if (Ld_A) regA <= sw;
    else if (Shift_En) regA <= {A_In, regA[7:1]};
    if (Ld_B) regB <= sw;
    else if (Shift_En) regB <= {B_In, regB[7:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Whole-operation result: each bit position is processed independently.
  function automatic logic [15:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] f, input logic [1:0] r);
    logic [7:0] y;
    case (f)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: y = 8'hFF;
      3'd4: y = ~(a & b);
      3'd5: y = ~(a | b);
      3'd6: y = ~(a ^ b);
      default: y = 8'h00;
    endcase
    case (r)
      2'd0: return {a, b};
      2'd1: return {a, y};
      2'd2: return {y, b};
      default: return {b, a};
    endcase
  endfunction

  task automatic load_a(input logic [7:0] v);
    sw = v; LoadA = 1'b1;
    #1 chk("ld_a_strobe", {31'd0, Ld_A}, 32'd1);
    tick();
    LoadA = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] v);
    sw = v; LoadB = 1'b1;
    #1 chk("ld_b_strobe", {31'd0, Ld_B}, 32'd1);
    tick();
    LoadB = 1'b0;
  endtask

  task automatic wait_burst(input bit disturb, output int n);
    int guard;
    n = 0;
    guard = 0;
    while (Shift_En === 1'b1 && guard < 4 * WIDTH) begin
      chk("busy", {31'd0, Busy}, 32'd1);
      if (disturb) begin
        F = 3'($urandom); R = 2'($urandom); sw = 8'($urandom);
        LoadA = 1'($urandom); LoadB = 1'($urandom);
        #1 chk("shift_ld", {30'd0, Ld_A, Ld_B}, 32'd0);
      end
      n++;
      guard++;
      tick();
    end
    LoadA = 1'b0;
    LoadB = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                        input logic [1:0] r, input int extra, input bit disturb,
                        input bit do_load, input bit ld_exec, input bit stay);
    logic [7:0]  a0, b0;
    logic [15:0] e;
    int n;
    if (do_load) begin
      load_a(a);
      load_b(b);
    end
    a0 = regA;
    b0 = regB;
    if (do_load) begin
      chk("pre_a", {24'd0, a0}, {24'd0, a});
      chk("pre_b", {24'd0, b0}, {24'd0, b});
    end
    e = ref_op(a0, b0, f, r);
    F = f; R = r; Execute = 1'b1;
    if (ld_exec) begin
      sw = ~a0; LoadA = 1'b1; LoadB = 1'b1;
      #1 chk("ld_with_exec", {30'd0, Ld_A, Ld_B}, 32'd0);
    end
    tick();
    LoadA = 1'b0; LoadB = 1'b0;
    chk("start", {31'd0, Shift_En}, 32'd1);
    wait_burst(disturb, n);
    chk("nshift", n, WIDTH);
    chk("done", {31'd0, Done}, 32'd1);
    chk("busy_off", {31'd0, Busy}, 32'd0);
    chk("res_a", {24'd0, regA}, {24'd0, e[15:8]});
    chk("res_b", {24'd0, regB}, {24'd0, e[7:0]});
    for (int i = 0; i < extra; i++) begin
      sw = 8'($urandom); LoadA = 1'b1;
      #1 chk("hold_ld", {31'd0, Ld_A}, 32'd0);
      chk("hold_se", {31'd0, Shift_En}, 32'd0);
      chk("hold_done", {31'd0, Done}, 32'd1);
      tick();
    end
    LoadA = 1'b0;
    if (extra > 0) begin
      chk("hold_keep_a", {24'd0, regA}, {24'd0, e[15:8]});
    end
    if (!stay) begin
      Execute = 1'b0;
      tick();
      chk("idle", {31'd0, Done}, 32'd0);
    end
  endtask

  initial begin
    int n;
    logic [15:0] e;

    // Reset held: strobes low even with requests present.
    LoadA = 1'b1; Execute = 1'b1;
    #3;
    chk("rst_ld_a", {31'd0, Ld_A}, 32'd0);
    chk("rst_se", {31'd0, Shift_En}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    tick();
    chk("rst_se_edge", {31'd0, Shift_En}, 32'd0);
    chk("rst_route", {30'd0, A_In, B_In}, {30'd0, A_out, B_out});
    LoadA = 1'b0; Execute = 1'b0;
    Reset = 1'b1;
    tick();

    // Directed operations.
    run_op(8'h33, 8'h55, 3'd0, 2'd2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h33, 8'h55, 3'd2, 2'd1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h33, 8'h55, 3'd7, 2'd2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h33, 8'h55, 3'd5, 2'd3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h33, 8'h55, 3'd4, 2'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Execute held long with disturbance, then 1-cycle turnaround.
    run_op(8'hA7, 8'h3C, 3'd6, 2'd1, 22, 1'b1, 1'b1, 1'b0, 1'b1);
    e = ref_op(regA, regB, 3'd1, 2'd2);
    Execute = 1'b0;
    tick();
    chk("turn_idle", {31'd0, Done}, 32'd0);
    F = 3'd1; R = 2'd2; Execute = 1'b1;
    tick();
    chk("turn_start", {31'd0, Shift_En}, 32'd1);
    wait_burst(1'b1, n);
    chk("turn_nshift", n, WIDTH);
    chk("turn_a", {24'd0, regA}, {24'd0, e[15:8]});
    chk("turn_b", {24'd0, regB}, {24'd0, e[7:0]});
    Execute = 1'b0;
    tick();

    // Load requested together with Execute: Execute wins.
    run_op(8'h0F, 8'hF0, 3'd1, 2'd2, 2, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the 4th shift cycle.
    load_a(8'h5A);
    F = 3'd3; R = 2'd2; Execute = 1'b1;
    tick();
    tick(); tick(); tick();
    chk("pre_rst_se", {31'd0, Shift_En}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_se", {31'd0, Shift_En}, 32'd0);
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_done", {31'd0, Done}, 32'd0);
    Execute = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    chk("arst_idle_done", {31'd0, Done}, 32'd0);
    run_op(8'hC3, 8'h96, 3'd2, 2'd2, 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      run_op(8'($urandom), 8'($urandom), 3'($urandom), 2'($urandom),
             int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
